toy_fetch_filter: RTL and testbench
===================================

# toy_fetch_filter

Fetch-line filter stage sitting directly upstream of the fetch queue. It takes one I-cache line response per cycle, marks the instruction slots that belong to the current fetch stream (start offset through predicted-taken end offset), and expands each slot to a PC-tagged `fetch_queue_pkg`. Results pass through a 2-entry output buffer into the queue's `filter_vld/filter_rdy` write port. An epoch counter discards stale lines that were in flight when a pipeline cancel occurred.

## Interface
Parameters:
- `FILTER_CHANNEL`, 16, instruction slots per line; power of 2; equals the fetch-queue write width.
- `ADDR_WIDTH`, 32, PC width.
- `INST_WIDTH`, 32, instruction width; slot stride in PC is 4 bytes.
- `EPOCH_WIDTH`, 2, width of the cancel epoch tag.

Ports (`OW = $clog2(FILTER_CHANNEL)`):
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cancel_en`  in  1  pipeline flush; shared with the fetch queue.
- `line_vld`  in  1  line response valid.
- `line_rdy`  out  1  line response accepted.
- `line_pc`  in  ADDR_WIDTH  line base PC; low `OW+2` bits are ignored and treated as 0.
- `line_data`  in  FILTER_CHANNEL*INST_WIDTH  slot k occupies bits `[k*INST_WIDTH +: INST_WIDTH]`.
- `line_start_off`  in  OW  first valid slot.
- `line_end_off`  in  OW  last valid slot, inclusive.
- `line_taken`  in  1  the slot at `line_end_off` is a predicted-taken branch.
- `line_epoch`  in  EPOCH_WIDTH  epoch the request was issued under.
- `cur_epoch`  out  EPOCH_WIDTH  current epoch, sent to the fetch request generator.
- `filter_vld`  out  1  output entry valid.
- `filter_rdy`  in  1  the fetch queue accepts the entry.
- `filter_pld`  out  fetch_queue_pkg [FILTER_CHANNEL]  per-slot payload.
- `filter_en`  out  FILTER_CHANNEL  per-slot valid mask.
- `drop_cnt`  out  16  saturating count of discarded lines.

## Operation
- **Accept:** `acc = line_vld & line_rdy & ~cancel_en`.
- **Discard:** an accepted line is dropped (consumed, not written, `drop_cnt`+1) when either holds:
  - `line_epoch != cur_epoch`;
  - `line_start_off > line_end_off`.
- **Mask:** `en[k] = (k >= start_off) & (k <= end_off)`.
- **Payload:** for each slot k:
  - `inst_pc = {line_pc[ADDR_WIDTH-1:OW+2], OW'(k), 2'b00}`;
  - `inst = slot k`;
  - `pred_taken = line_taken & (k == end_off)`.
  - Payload is computed before the buffer write and stored registered.
- **Buffer:** 2-entry FIFO.
  - `line_rdy = (count < 2)`, driven from registered count only; no same-cycle pop bypass.
  - `filter_vld = (count != 0)`.
  - `filter_pld`/`filter_en` come from the head entry; they are 0 when empty.
  - Pop on `filter_vld & filter_rdy`.
  - Simultaneous push and pop keeps count unchanged.
- **Cancel** (highest priority, single cycle):
  - count ← 0;
  - `cur_epoch` ← `cur_epoch + 1`, wrapping modulo 2^EPOCH_WIDTH;
  - no push that cycle;
  - a pop in the same cycle still completes at the queue, but the queue also flushes.
- **`drop_cnt`:** saturates at 16'hFFFF and is not cleared by cancel.

## Timing
- **Reset values:**
  - count 0, so `line_rdy`=1 and `filter_vld`=0;
  - `filter_en`=0, `filter_pld`=0;
  - `cur_epoch`=0, `drop_cnt`=0.
- **Latency:** line accepted in cycle N → `filter_vld`=1 in N+1.
- **Throughput:** 1 line/cycle with `filter_rdy` held high.
- **Stall:** `filter_vld`/`filter_pld`/`filter_en` hold stable while `filter_rdy`=0.
- **Full:** `line_rdy`=0 in the cycle after the second unpopped push. It returns to 1 the cycle after a pop.
- **Epoch:** the increment is visible on `cur_epoch` in the cycle after `cancel_en`. A line carrying the new epoch is accepted from that cycle onward.
- **Reset mid-operation:** asynchronous clear of all state; no partial entry is emitted.

## Structure
- Shared package `toy_pack` defines:
  - `fetch_queue_pkg` with fields `inst_pc`, `inst`, `pred_taken`;
  - `FILTER_CHANNEL`, `ADDR_WIDTH`, `INST_WIDTH`.
- One sub-module, `toy_fetch_filter_buf`: the 2-entry FIFO of {pld array, en mask} with push/pop/flush and count.
- Mask/PC generation and the epoch/drop logic live in the top module.

## Test plan
- **Single line:** pc=0x1000, start=3, end=9, taken=1, epoch 0, `filter_rdy`=1.
  - Next cycle: `filter_en`=0x03F8.
  - slot3 pc=0x100C; slot9 pc=0x1024 with pred_taken=1; all other pred_taken=0.
- **Back-pressure:** 3 lines back-to-back with `filter_rdy`=0.
  - Two are accepted; `line_rdy`=0 on the third.
  - Raise `filter_rdy`: entries pop in order, and the third is accepted the cycle after the first pop.
- **Cancel with 2 entries buffered:**
  - `filter_vld`=0 the next cycle; `cur_epoch` 0→1.
  - A subsequent line tagged epoch 0 is dropped with `drop_cnt`=1; a line tagged epoch 1 passes.
- **Empty range:** start=12, end=4 → line consumed, nothing emitted, `drop_cnt`+1.
- **Epoch wrap:** 4 cancels → `cur_epoch` 0→1→2→3→0; an epoch-0 line is then accepted.
- **Reset mid-stream:** assert `rst_n`=0 with 1 entry buffered → `filter_vld`=0 immediately; after release `line_rdy`=1, epoch 0, drop_cnt 0.

Source files
------------

// File: rtl/toy_fetch_filter_pkg.sv
// toy_pack: shared fetch-path types and sizing for the fetch filter and fetch queue.
//    FILTER_CHANNEL  slots per I-cache line / fetch-queue write width
//    ADDR_WIDTH      PC width
//    INST_WIDTH      instruction width
//    EPOCH_WIDTH     cancel epoch tag width
//    fetch_queue_pkg per-slot payload {inst_pc, inst, pred_taken}
package toy_pack;
   localparam int FILTER_CHANNEL = 16;
   localparam int ADDR_WIDTH     = 32;
   localparam int INST_WIDTH     = 32;
   localparam int EPOCH_WIDTH    = 2;
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] inst_pc;
      logic [INST_WIDTH-1:0] inst;
      logic                  pred_taken;
   } fetch_queue_pkg;
endpackage

// File: rtl/toy_fetch_filter_buf.sv
// toy_fetch_filter_buf: 2-entry output FIFO of {payload array, slot mask}.
//    clk, rst_n      clock, asynchronous active-low reset
//    push_i          write push_pld_i/push_en_i (caller guarantees not full)
//    pop_i           retire the head entry (caller guarantees not empty)
//    flush_i         empty the FIFO; wins over push/pop
//    count_o         occupancy 0..2
//    vld_o           head entry present
//    pld_o, en_o     head entry, forced to 0 when empty
module toy_fetch_filter_buf
   import toy_pack::*;
#(
   parameter int CH = FILTER_CHANNEL
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push_i,
   input  logic           pop_i,
   input  logic           flush_i,
   input  fetch_queue_pkg push_pld_i [CH],
   input  logic [CH-1:0]  push_en_i,
   output logic [1:0]     count_o,
   output logic           vld_o,
   output fetch_queue_pkg pld_o [CH],
   output logic [CH-1:0]  en_o
);
   logic [1:0]     count_q, count_d;
   logic           wr_q, wr_d, rd_q, rd_d;
   fetch_queue_pkg pld_q [2][CH];
   logic [CH-1:0]  en_q [2];

   always_comb begin
      count_d = flush_i ? 2'd0 : count_q + {1'b0, push_i} - {1'b0, pop_i};
      wr_d    = flush_i ? 1'b0 : wr_q ^ push_i;
      rd_d    = flush_i ? 1'b0 : rd_q ^ pop_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   // Storage needs no reset: every read of it is gated by the registered count.
   always_ff @(posedge clk) begin
      if (push_i) begin
         pld_q[wr_q] <= push_pld_i;
         en_q[wr_q]  <= push_en_i;
      end
   end

   assign count_o = count_q;
   assign vld_o   = count_q != 2'd0;
   assign en_o    = vld_o ? en_q[rd_q] : '0;

   always_comb begin
      for (int k = 0; k < CH; k++) pld_o[k] = vld_o ? pld_q[rd_q][k] : '0;
   end
endmodule

// File: rtl/toy_fetch_filter.sv
// toy_fetch_filter: marks the in-stream slots of an I-cache line, tags each with its PC,
// and hands the line to the fetch queue through a 2-entry buffer; stale lines are dropped.
//    clk, rst_n             clock, asynchronous active-low reset
//    cancel_en              pipeline flush: empties buffer, bumps epoch
//    line_vld/line_rdy      line response handshake
//    line_pc                line base PC (low OW+2 bits ignored)
//    line_data              FILTER_CHANNEL instructions, slot k at [k*INST_WIDTH +: INST_WIDTH]
//    line_start_off/end_off first / last (inclusive) slot of the fetch stream
//    line_taken             slot at line_end_off is predicted taken
//    line_epoch, cur_epoch  request epoch tag / current epoch
//    filter_vld/filter_rdy  fetch-queue write handshake
//    filter_pld, filter_en  per-slot payload and valid mask
//    drop_cnt               saturating count of discarded lines
module toy_fetch_filter #(
   parameter  int FILTER_CHANNEL = toy_pack::FILTER_CHANNEL,
   parameter  int ADDR_WIDTH     = toy_pack::ADDR_WIDTH,
   parameter  int INST_WIDTH     = toy_pack::INST_WIDTH,
   parameter  int EPOCH_WIDTH    = toy_pack::EPOCH_WIDTH,
   localparam int OW             = $clog2(FILTER_CHANNEL)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cancel_en,
   input  logic                           line_vld,
   output logic                           line_rdy,
   input  logic [ADDR_WIDTH-1:0]          line_pc,
   input  logic [FILTER_CHANNEL*INST_WIDTH-1:0] line_data,
   input  logic [OW-1:0]                  line_start_off,
   input  logic [OW-1:0]                  line_end_off,
   input  logic                           line_taken,
   input  logic [EPOCH_WIDTH-1:0]         line_epoch,
   output logic [EPOCH_WIDTH-1:0]         cur_epoch,
   output logic                           filter_vld,
   input  logic                           filter_rdy,
   output toy_pack::fetch_queue_pkg       filter_pld [FILTER_CHANNEL],
   output logic [FILTER_CHANNEL-1:0]      filter_en,
   output logic [15:0]                    drop_cnt
);
   import toy_pack::*;

   logic [EPOCH_WIDTH-1:0]    epoch_q, epoch_d;
   logic [15:0]               drop_cnt_q, drop_cnt_d;
   logic [1:0]                count;
   logic                      acc, drop, push, pop;
   logic [FILTER_CHANNEL-1:0] en;
   fetch_queue_pkg            pld [FILTER_CHANNEL];
   logic                      pc_low_unused;

   assign pc_low_unused = ^line_pc[OW+1:0];

   assign line_rdy   = count < 2'd2;
   assign acc        = line_vld & line_rdy & ~cancel_en;
   assign drop       = acc & ((line_epoch != epoch_q) | (line_start_off > line_end_off));
   assign push       = acc & ~drop;
   assign pop        = filter_vld & filter_rdy;
   assign epoch_d    = cancel_en ? epoch_q + EPOCH_WIDTH'(1) : epoch_q;
   assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epoch_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         epoch_q    <= epoch_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      for (int k = 0; k < FILTER_CHANNEL; k++) begin
         en[k]              = (OW'(k) >= line_start_off) && (OW'(k) <= line_end_off);
         pld[k].inst_pc     = {line_pc[ADDR_WIDTH-1:OW+2], OW'(k), 2'b00};
         pld[k].inst        = line_data[k*INST_WIDTH +: INST_WIDTH];
         pld[k].pred_taken  = line_taken && (OW'(k) == line_end_off);
      end
   end

   // Cancel flushes the buffer; push is already suppressed through acc.
   toy_fetch_filter_buf #(.CH(FILTER_CHANNEL)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .pop_i      (pop),
      .flush_i    (cancel_en),
      .push_pld_i (pld),
      .push_en_i  (en),
      .count_o    (count),
      .vld_o      (filter_vld),
      .pld_o      (filter_pld),
      .en_o       (filter_en)
   );

   assign cur_epoch = epoch_q;
   assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_toy_fetch_filter.sv
// tb_toy_fetch_filter: directed scoreboard bench for toy_fetch_filter.
module tb_toy_fetch_filter;
   import toy_pack::*;

   localparam int CH = 16;

   typedef struct packed {
      logic [CH-1:0]                en;
      fetch_queue_pkg [CH-1:0]      pld;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cancel_en = 1'b0;
   logic              line_vld = 1'b0;
   logic              line_rdy;
   logic [31:0]       line_pc = '0;
   logic [CH*32-1:0]  line_data = '0;
   logic [3:0]        line_start_off = '0;
   logic [3:0]        line_end_off = '0;
   logic              line_taken = 1'b0;
   logic [1:0]        line_epoch = '0;
   logic [1:0]        cur_epoch;
   logic              filter_vld;
   logic              filter_rdy = 1'b1;
   fetch_queue_pkg    filter_pld [CH];
   logic [CH-1:0]     filter_en;
   logic [15:0]       drop_cnt;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [1:0]  exp_epoch = '0;
   logic [15:0] exp_drop = '0;
   logic [15:0] cur_seed = '0;
   logic        last_acc = 1'b0;
   logic [1:0]  wrap_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

   toy_fetch_filter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cancel_en      (cancel_en),
      .line_vld       (line_vld),
      .line_rdy       (line_rdy),
      .line_pc        (line_pc),
      .line_data      (line_data),
      .line_start_off (line_start_off),
      .line_end_off   (line_end_off),
      .line_taken     (line_taken),
      .line_epoch     (line_epoch),
      .cur_epoch      (cur_epoch),
      .filter_vld     (filter_vld),
      .filter_rdy     (filter_rdy),
      .filter_pld     (filter_pld),
      .filter_en      (filter_en),
      .drop_cnt       (drop_cnt)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic set_line(input logic [31:0] pc, input int s, input int e, input logic t,
                           input logic [1:0] ep, input logic [15:0] seed);
      line_vld       = 1'b1;
      line_pc        = pc;
      line_start_off = 4'(s);
      line_end_off   = 4'(e);
      line_taken     = t;
      line_epoch     = ep;
      cur_seed       = seed;
      for (int k = 0; k < CH; k++) line_data[k*32 +: 32] = {seed, 16'(k)};
   endtask

   function automatic exp_t model();
      exp_t m;
      for (int k = 0; k < CH; k++) begin
         m.en[k]             = (k >= int'(line_start_off)) && (k <= int'(line_end_off));
         m.pld[k].inst_pc    = {line_pc[31:6], 4'(k), 2'b00};
         m.pld[k].inst       = {cur_seed, 16'(k)};
         m.pld[k].pred_taken = line_taken && (k == int'(line_end_off));
      end
      return m;
   endfunction

   // One clock: decide acceptance at the negedge, update the scoreboard at the posedge.
   task automatic step();
      logic acc, can, bad;
      @(negedge clk);
      can = cancel_en;
      acc = line_vld && line_rdy && !cancel_en;
      bad = (line_epoch != exp_epoch) || (line_start_off > line_end_off);
      @(posedge clk);
      last_acc = acc;
      if (can) begin
         exp_q.delete();
         exp_epoch++;
      end
      if (acc && bad && exp_drop != 16'hFFFF) exp_drop++;
      if (acc && !bad) exp_q.push_back(model());
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: whenever an entry is presented, compare it with the scoreboard head.
   initial forever begin
      @(negedge clk);
      if (rst_n && filter_vld) begin
         if (exp_q.size() == 0) chk("unexpected_entry", 1, 0);
         else begin
            chk("entry_en", filter_en, exp_q[0].en);
            for (int k = 0; k < CH; k++) chk($sformatf("entry_slot%0d", k), filter_pld[k], exp_q[0].pld[k]);
            if (filter_rdy) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      @(negedge clk);
      chk("rst_line_rdy", line_rdy, 1);
      chk("rst_filter_vld", filter_vld, 0);
      chk("rst_filter_en", filter_en, 0);
      chk("rst_filter_pld0", filter_pld[0], 0);
      chk("rst_cur_epoch", cur_epoch, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);
      // single line
      set_line(32'h1000, 3, 9, 1'b1, 2'd0, 16'hA001);
      step();
      chk("single_acc", last_acc, 1);
      line_vld = 1'b0;
      @(negedge clk);
      chk("single_en", filter_en, 16'h03F8);
      chk("single_pc3", filter_pld[3].inst_pc, 32'h100C);
      chk("single_pc9", filter_pld[9].inst_pc, 32'h1024);
      chk("single_pred9", filter_pld[9].pred_taken, 1);
      chk("single_pred8", filter_pld[8].pred_taken, 0);
      chk("single_pred3", filter_pld[3].pred_taken, 0);
      chk("single_inst3", filter_pld[3].inst, 32'hA001_0003);
      @(posedge clk);
      #1;
      // back-to-back at full rate, unaligned PC, full range, single-slot range
      set_line(32'h2034, 0, 15, 1'b0, 2'd0, 16'hB002);
      step();
      chk("b2b_acc0", last_acc, 1);
      set_line(32'h30C0, 5, 5, 1'b1, 2'd0, 16'hB003);
      step();
      chk("b2b_acc1", last_acc, 1);
      set_line(32'hFFFF_FFC4, 0, 0, 1'b1, 2'd0, 16'hB004);
      step();
      chk("b2b_acc2", last_acc, 1);
      line_vld = 1'b0;
      idle(3);
      // back-pressure
      filter_rdy = 1'b0;
      set_line(32'h4000, 1, 2, 1'b0, 2'd0, 16'hC001);
      step();
      chk("bp_acc_a", last_acc, 1);
      set_line(32'h4040, 2, 14, 1'b1, 2'd0, 16'hC002);
      step();
      chk("bp_acc_b", last_acc, 1);
      set_line(32'h4080, 0, 7, 1'b0, 2'd0, 16'hC003);
      step();
      chk("bp_full_c", last_acc, 0);
      filter_rdy = 1'b1;
      step();
      chk("bp_pop_cycle_c", last_acc, 0);
      step();
      chk("bp_after_pop_c", last_acc, 1);
      line_vld = 1'b0;
      idle(4);
      // cancel with two entries buffered
      filter_rdy = 1'b0;
      set_line(32'h5000, 0, 3, 1'b0, 2'd0, 16'hD001);
      step();
      set_line(32'h5040, 4, 8, 1'b0, 2'd0, 16'hD002);
      step();
      line_vld = 1'b0;
      cancel_en = 1'b1;
      step();
      cancel_en = 1'b0;
      @(negedge clk);
      chk("cancel_vld", filter_vld, 0);
      chk("cancel_epoch", cur_epoch, 1);
      chk("cancel_epoch_model", cur_epoch, exp_epoch);
      @(posedge clk);
      #1 filter_rdy = 1'b1;
      set_line(32'h6000, 0, 3, 1'b0, 2'd0, 16'hD003);
      step();
      chk("stale_consumed", last_acc, 1);
      line_vld = 1'b0;
      @(negedge clk);
      chk("stale_drop_cnt", drop_cnt, 16'd1);
      chk("stale_no_vld", filter_vld, 0);
      @(posedge clk);
      #1;
      set_line(32'h6040, 2, 6, 1'b1, 2'd1, 16'hD004);
      step();
      line_vld = 1'b0;
      @(negedge clk);
      chk("fresh_vld", filter_vld, 1);
      @(posedge clk);
      #1;
      idle(2);
      // empty range
      set_line(32'h7000, 12, 4, 1'b0, 2'd1, 16'hE001);
      step();
      chk("empty_consumed", last_acc, 1);
      line_vld = 1'b0;
      @(negedge clk);
      chk("empty_no_vld", filter_vld, 0);
      chk("empty_drop_cnt", drop_cnt, 16'd2);
      chk("empty_drop_model", drop_cnt, exp_drop);
      @(posedge clk);
      #1;
      // reset mid-stream with one entry buffered
      filter_rdy = 1'b0;
      set_line(32'h8000, 0, 1, 1'b0, 2'd1, 16'hF001);
      step();
      chk("rst_mid_acc", last_acc, 1);
      line_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_vld", filter_vld, 0);
      exp_q.delete();
      exp_epoch = '0;
      exp_drop = '0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_line_rdy", line_rdy, 1);
      chk("rst_mid_epoch", cur_epoch, 0);
      chk("rst_mid_drop_cnt", drop_cnt, 0);
      chk("rst_mid_vld_after", filter_vld, 0);
      @(posedge clk);
      #1 filter_rdy = 1'b1;
      // epoch wrap
      for (int i = 0; i < 4; i++) begin
         cancel_en = 1'b1;
         step();
         cancel_en = 1'b0;
         @(negedge clk);
         chk($sformatf("wrap_epoch%0d", i), cur_epoch, wrap_seq[i]);
         @(posedge clk);
         #1;
      end
      set_line(32'h9000, 6, 10, 1'b1, 2'd0, 16'h9001);
      step();
      chk("wrap_acc", last_acc, 1);
      line_vld = 1'b0;
      @(negedge clk);
      chk("wrap_vld", filter_vld, 1);
      chk("wrap_drop_cnt", drop_cnt, 0);
      @(posedge clk);
      #1;
      idle(3);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
